// File: rtl/csk_pkg.sv
// Shared types and sizing helpers for the borrow-skip subtractor.
// Provides the FSM state enum, default block size and counter sizing.
package csk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CSK_BLK = 4;

  function automatic int nblk(
    input int width,
    input int blk
  );
    return width / blk;
  endfunction

  // A single-block build still needs a 1-bit counter.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/csk_subtractor_seq_if.sv
// Operand/result handshake bundle for csk_subtractor_seq.
// master: drives operands and out_ready; slave: the subtractor.
// OVF is present only when CSK_SUB_OVF_EN is defined.
interface csk_subtractor_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             BIN;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] DIFF;
  logic             BOUT;
`ifdef CSK_SUB_OVF_EN
  logic             OVF;
`endif

  modport master (
    output in_valid,
    input  in_ready,
    output A,
    output B,
    output BIN,
    input  out_valid,
    output out_ready,
    input  DIFF,
`ifdef CSK_SUB_OVF_EN
    input  OVF,
`endif
    input  BOUT
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  A,
    input  B,
    input  BIN,
    output out_valid,
    input  out_ready,
    output DIFF,
`ifdef CSK_SUB_OVF_EN
    output OVF,
`endif
    output BOUT
  );

endinterface

// File: rtl/csk_sub_block.sv
// Combinational BLK-bit borrow-skip subtractor: d = a - b - bin.
// Ports: a, b (BLK), bin -> d (BLK), bout (block borrow-out).
module csk_sub_block
  import csk_pkg::*;
#(
  parameter int BLK = CSK_BLK
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           bin,
  output logic [BLK-1:0] d,
  output logic           bout
);

  logic [BLK-1:0] p;
  logic [BLK-1:0] g;
  logic [BLK:0]   c;

  assign p = ~(a ^ b);
  assign g = ~a & b;

  always_comb begin
    c    = '0;
    c[0] = bin;
    for (int i = 0; i < BLK; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign d = a ^ b ^ c[BLK-1:0];

  // When every bit propagates, the borrow bypasses the ripple chain.
  assign bout = (&p) ? bin : c[BLK];

endmodule

// File: rtl/csk_subtractor_seq.sv
// Multi-cycle borrow-skip subtractor, one BLK-bit block per clock.
// Ports: clk, rst (async, active-high), bus (slave handshake bundle:
// in_valid/in_ready/A/B/BIN in, out_valid/out_ready/DIFF/BOUT out).
// Optional macro CSK_SUB_OVF_EN adds the registered OVF output.
module csk_subtractor_seq
  import csk_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BLK   = CSK_BLK
) (
  input  logic                 clk,
  input  logic                 rst,
  csk_subtractor_seq_if.slave  bus
);

  localparam int NBLK = nblk(WIDTH, BLK);
  localparam int CW   = cnt_w(NBLK);
  localparam logic [CW-1:0] LAST = CW'(NBLK - 1);

  if ((WIDTH % BLK) != 0) begin : g_bad_width
    $error("WIDTH must be a multiple of BLK");
  end

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    cnt_q;
  logic             brw_q;
  logic             bout_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [BLK-1:0]   a_blk;
  logic [BLK-1:0]   b_blk;
  logic [BLK-1:0]   d_blk;
  logic             bo_blk;

  assign a_blk = a_q[int'(cnt_q) * BLK +: BLK];
  assign b_blk = b_q[int'(cnt_q) * BLK +: BLK];

  csk_sub_block #(
    .BLK (BLK)
  ) u_blk (
    .a    (a_blk),
    .b    (b_blk),
    .bin  (brw_q),
    .d    (d_blk),
    .bout (bo_blk)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      diff_q      <= '0;
      cnt_q       <= '0;
      brw_q       <= 1'b0;
      bout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.A;
            b_q        <= bus.B;
            brw_q      <= bus.BIN;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          diff_q[int'(cnt_q) * BLK +: BLK] <= d_blk;
          brw_q <= bo_blk;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            bout_q      <= bo_blk;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef CSK_SUB_OVF_EN
  logic ovf_q;

  // Sign of the result comes from the top block being written this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (state == RUN && cnt_q == LAST) begin
      ovf_q <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
               (d_blk[BLK-1] != a_q[WIDTH-1]);
    end
  end

  assign bus.OVF = ovf_q;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.DIFF      = diff_q;
  assign bus.BOUT      = bout_q;

endmodule
